// File: rtl/maxpool_relu_pkg.sv
// Shared constants, sample type and signed compare helpers for the 2x2 max-pool + ReLU stage.
package maxpool_relu_pkg;

    localparam int CONV_BIT    = 12;
    localparam int IN_WIDTH    = 24;
    localparam int IN_HEIGHT   = 24;
    localparam int POOL_WIDTH  = IN_WIDTH / 2;
    localparam int POOL_HEIGHT = IN_HEIGHT / 2;
    localparam int COL_W       = $clog2(IN_WIDTH);
    localparam int ROW_W       = $clog2(IN_HEIGHT);
    localparam int POOL_IDX_W  = $clog2(POOL_WIDTH);

    typedef logic signed [CONV_BIT-1:0] sample_t;

    function automatic sample_t max2(input sample_t a, input sample_t b);
        sample_t r;
        if (a > b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

    function automatic sample_t relu(input sample_t a);
        sample_t r;
        if (a[CONV_BIT-1]) begin
            r = {CONV_BIT{1'b0}};
        end else begin
            r = a;
        end
        return r;
    endfunction

endpackage

// File: rtl/maxpool_relu_if.sv
// Conv-stage sample stream in, pooled valid-qualified stream out.
interface maxpool_relu_if;
    import maxpool_relu_pkg::*;

    logic    valid_in;
    sample_t conv_in_1;
    sample_t conv_in_2;
    sample_t conv_in_3;
    sample_t max_value_1;
    sample_t max_value_2;
    sample_t max_value_3;
    logic    valid_out_relu;

    modport master (
        output valid_in, conv_in_1, conv_in_2, conv_in_3,
        input  max_value_1, max_value_2, max_value_3, valid_out_relu
    );

    modport slave (
        input  valid_in, conv_in_1, conv_in_2, conv_in_3,
        output max_value_1, max_value_2, max_value_3, valid_out_relu
    );

endinterface

// File: rtl/maxpool_lane.sv
// One channel of 2x2 max pooling: horizontal pair hold, half-row buffer, final compare and ReLU.
module maxpool_lane
    import maxpool_relu_pkg::*;
#(
    parameter int POOL_WIDTH = maxpool_relu_pkg::POOL_WIDTH,
    parameter int IDX_W      = maxpool_relu_pkg::POOL_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat,
    input  logic             col_odd,
    input  logic             row_odd,
    input  logic [IDX_W-1:0] idx,
    input  sample_t          sample,
    output sample_t          max_value
);

    sample_t hold_r;
    sample_t max_r;
    sample_t line_r [POOL_WIDTH];
    sample_t pair_s;
    sample_t quad_s;

    // Pair max of the current two columns, then fold in the stored upper-row pair.
    always_comb begin
        pair_s = max2(hold_r, sample);
        quad_s = max2(line_r[idx], pair_s);
    end

    // Hold register and registered ReLU result.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r <= {CONV_BIT{1'b0}};
            max_r  <= {CONV_BIT{1'b0}};
        end else begin
            if (beat && !col_odd) begin
                hold_r <= sample;
            end
            if (beat && col_odd && row_odd) begin
                max_r <= relu(quad_s);
            end
        end
    end

    // Half-row buffer: written on even rows, consumed on the next odd row, so no reset needed.
    always_ff @(posedge clk) begin
        if (beat && col_odd && !row_odd) begin
            line_r[idx] <= pair_s;
        end
    end

    assign max_value = max_r;

endmodule

// File: rtl/maxpool_relu.sv
// 2x2 stride-2 max pooling with ReLU over three channels; shared raster counters drive three lanes.
module maxpool_relu #(
    parameter int IN_WIDTH  = maxpool_relu_pkg::IN_WIDTH,
    parameter int IN_HEIGHT = maxpool_relu_pkg::IN_HEIGHT
) (
    input logic           clk,
    input logic           rst,
    maxpool_relu_if.slave bus
);
    import maxpool_relu_pkg::*;

    localparam int CW = $clog2(IN_WIDTH);
    localparam int RW = $clog2(IN_HEIGHT);
    localparam int PW = IN_WIDTH / 2;
    localparam int IW = CW - 1;

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic          valid_out_r;
    logic          col_odd_s;
    logic          row_odd_s;
    logic          last_col_s;
    logic          last_row_s;
    logic [IW-1:0] idx_s;
    sample_t       conv_s [3];
    sample_t       max_s  [3];

    // Phase decode broadcast to every lane.
    always_comb begin
        col_odd_s  = col_r[0];
        row_odd_s  = row_r[0];
        last_col_s = (col_r == CW'(IN_WIDTH - 1));
        last_row_s = (row_r == RW'(IN_HEIGHT - 1));
        idx_s      = col_r[CW-1:1];
        conv_s[0]  = bus.conv_in_1;
        conv_s[1]  = bus.conv_in_2;
        conv_s[2]  = bus.conv_in_3;
    end

    // Raster position counters and the output strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r       <= {CW{1'b0}};
            row_r       <= {RW{1'b0}};
            valid_out_r <= 1'b0;
        end else begin
            valid_out_r <= bus.valid_in && col_odd_s && row_odd_s;
            if (bus.valid_in) begin
                if (last_col_s) begin
                    col_r <= {CW{1'b0}};
                    if (last_row_s) begin
                        row_r <= {RW{1'b0}};
                    end else begin
                        row_r <= row_r + RW'(1);
                    end
                end else begin
                    col_r <= col_r + CW'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_lane
        maxpool_lane #(
            .POOL_WIDTH (PW),
            .IDX_W      (IW)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .beat      (bus.valid_in),
            .col_odd   (col_odd_s),
            .row_odd   (row_odd_s),
            .idx       (idx_s),
            .sample    (conv_s[i]),
            .max_value (max_s[i])
        );
    end

    assign bus.max_value_1    = max_s[0];
    assign bus.max_value_2    = max_s[1];
    assign bus.max_value_3    = max_s[2];
    assign bus.valid_out_relu = valid_out_r;

endmodule

// File: tb/tb_maxpool_relu.sv
// Randomized bench for maxpool_relu against a frame-array reference of 2x2 max + ReLU.
module tb_maxpool_relu;
    import maxpool_relu_pkg::*;

    localparam int FRAME = IN_WIDTH * IN_HEIGHT;
    localparam int NPOOL = POOL_WIDTH * POOL_HEIGHT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maxpool_relu_if bus();
    maxpool_relu dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int beat_cnt = 0;
    int strobe_cnt = 0;
    int first_v1 = -1;
    int last_v1 = -1;
    int exp_hold [3];
    int sent [3][IN_HEIGHT][IN_WIDTH];
    int frm  [3][IN_HEIGHT][IN_WIDTH];

    task automatic check_val(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    // One clock: drive, let the edge happen, update the model, compare.
    task automatic step(input bit v, input int d1, input int d2, input int d3);
        bit strobe;
        int r, c, m;
        int d [3];
        d[0] = d1; d[1] = d2; d[2] = d3;
        @(negedge clk);
        bus.valid_in  = v;
        bus.conv_in_1 = sample_t'(d1);
        bus.conv_in_2 = sample_t'(d2);
        bus.conv_in_3 = sample_t'(d3);
        @(posedge clk);
        strobe = 1'b0;
        if (v) begin
            r = beat_cnt / IN_WIDTH;
            c = beat_cnt % IN_WIDTH;
            for (int ch = 0; ch < 3; ch++) sent[ch][r][c] = d[ch];
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                strobe = 1'b1;
                strobe_cnt++;
                for (int ch = 0; ch < 3; ch++) begin
                    m = sent[ch][r][c];
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if (sent[ch][r-dr][c-dc] > m) m = sent[ch][r-dr][c-dc];
                    exp_hold[ch] = (m < 0) ? 0 : m;
                end
            end
            beat_cnt = (beat_cnt + 1) % FRAME;
        end
        #1;
        check_val("valid_out_relu", bus.valid_out_relu, strobe);
        check_val("max_value_1", bus.max_value_1, exp_hold[0]);
        check_val("max_value_2", bus.max_value_2, exp_hold[1]);
        check_val("max_value_3", bus.max_value_3, exp_hold[2]);
        if (strobe && strobe_cnt == 1) first_v1 = int'(bus.max_value_1);
        if (strobe && strobe_cnt == NPOOL) last_v1 = int'(bus.max_value_1);
    endtask

    // Reset for one cycle, optionally with a competing valid beat.
    task automatic do_reset(input bit with_valid);
        @(negedge clk);
        rst = 1'b1;
        bus.valid_in  = with_valid;
        bus.conv_in_1 = sample_t'(rnd_sample());
        bus.conv_in_2 = sample_t'(rnd_sample());
        bus.conv_in_3 = sample_t'(rnd_sample());
        @(posedge clk);
        #1;
        beat_cnt = 0;
        strobe_cnt = 0;
        for (int ch = 0; ch < 3; ch++) exp_hold[ch] = 0;
        check_val("rst_valid", bus.valid_out_relu, 0);
        check_val("rst_max1", bus.max_value_1, 0);
        check_val("rst_max2", bus.max_value_2, 0);
        check_val("rst_max3", bus.max_value_3, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.valid_in = 1'b0;
    endtask

    task automatic gen_ramp();
        for (int r = 0; r < IN_HEIGHT; r++)
            for (int c = 0; c < IN_WIDTH; c++) begin
                frm[0][r][c] = r * IN_WIDTH + c;
                frm[1][r][c] = -100;
                frm[2][r][c] = rnd_sample();
            end
        frm[2][0][0] = -5;    frm[2][0][1] = 7;     frm[2][1][0] = -2048; frm[2][1][1] = 3;
        frm[2][0][2] = 2047;  frm[2][0][3] = -2048; frm[2][1][2] = 0;     frm[2][1][3] = 1;
        frm[2][0][4] = -2048; frm[2][0][5] = -2048; frm[2][1][4] = -2048; frm[2][1][5] = -2048;
    endtask

    task automatic gen_random();
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < IN_HEIGHT; r++)
                for (int c = 0; c < IN_WIDTH; c++) frm[ch][r][c] = rnd_sample();
    endtask

    task automatic send_frame(input int max_gap, input int n_beats);
        int k;
        k = 0;
        for (int r = 0; r < IN_HEIGHT; r++)
            for (int c = 0; c < IN_WIDTH; c++) begin
                if (k < n_beats) begin
                    step(1'b1, frm[0][r][c], frm[1][r][c], frm[2][r][c]);
                    repeat ($urandom_range(0, max_gap)) step(1'b0, rnd_sample(), rnd_sample(), rnd_sample());
                end
                k++;
            end
    endtask

    initial begin
        bus.valid_in  = 1'b0;
        bus.conv_in_1 = '0;
        bus.conv_in_2 = '0;
        bus.conv_in_3 = '0;
        for (int ch = 0; ch < 3; ch++) exp_hold[ch] = 0;
        do_reset(1'b1);

        gen_ramp();
        strobe_cnt = 0;
        send_frame(0, FRAME);
        check_val("ramp_strobes", strobe_cnt, NPOOL);
        check_val("ramp_first", first_v1, 25);
        check_val("ramp_last", last_v1, 575);

        strobe_cnt = 0; first_v1 = -1; last_v1 = -1;
        send_frame(3, FRAME);
        check_val("gap_strobes", strobe_cnt, NPOOL);
        check_val("gap_first", first_v1, 25);
        check_val("gap_last", last_v1, 575);

        gen_random();
        send_frame(1, 300);
        do_reset(1'b1);
        gen_ramp();
        first_v1 = -1; last_v1 = -1;
        send_frame(0, FRAME);
        check_val("rst_frame_strobes", strobe_cnt, NPOOL);
        check_val("rst_frame_first", first_v1, 25);
        check_val("rst_frame_last", last_v1, 575);

        strobe_cnt = 0;
        gen_random();
        send_frame(0, FRAME);
        gen_random();
        send_frame(0, FRAME);
        check_val("b2b_strobes", strobe_cnt, 2 * NPOOL);

        repeat (4) step(1'b0, rnd_sample(), rnd_sample(), rnd_sample());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
